// File: rtl/core_trap_entry.sv
// -----------------------------------------------------------------------------
// core_trap_entry
//
// Trap entry sequencer. On a trap_req strobe in IDLE it picks the winning trap
// source (exception > M interrupt > S interrupt) and latches it. It resolves the
// target privilege through medeleg and precomputes the trap vector. It then
// writes xEPC, xCAUSE and xTVAL over a valid/ready CSR write port, pulses the
// status update for one cycle, and finally redirects fetch for one cycle.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   trap_req               controller strobe, sampled only in IDLE
//   exception_*            synchronous exception valid / cause / tval
//   m_interrupt_*          M-level interrupt valid / cause
//   s_interrupt_*          S-level interrupt valid / cause
//   pc, priv               trapping PC and current privilege (U=0, S=1, M=3)
//   medeleg, mtvec, stvec  delegation mask and trap vector CSRs
//   csr_wr_*               CSR write request (valid/addr/data) and ready
//   status_update          one-cycle pulse that updates mstatus/sstatus
//   status_target          target privilege (1=S, 3=M)
//   redirect_valid/pc      one-cycle fetch redirect to the trap vector
//   busy                   high whenever a trap sequence is in flight
//
// Every output is decoded from the registered state and the latched fields, so
// there is no combinational path from the trap inputs to any output.
// -----------------------------------------------------------------------------
module core_trap_entry #(
  parameter int CAUSE_W     = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trap_req,
  input  logic               exception_valid,
  input  logic [CAUSE_W-1:0] exception_cause,
  input  logic [31:0]        exception_value,
  input  logic               m_interrupt_valid,
  input  logic [CAUSE_W-1:0] m_interrupt_cause,
  input  logic               s_interrupt_valid,
  input  logic [CAUSE_W-1:0] s_interrupt_cause,
  input  logic [31:0]        pc,
  input  logic [1:0]         priv,
  input  logic [15:0]        medeleg,
  input  logic [31:0]        mtvec,
  input  logic [31:0]        stvec,
  output logic               csr_wr_valid,
  output logic [11:0]        csr_wr_addr,
  output logic [31:0]        csr_wr_data,
  input  logic               csr_wr_ready,
  output logic               status_update,
  output logic [1:0]         status_target,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
    WR_TVAL,
    STATUS,
    REDIRECT
  } state_t;

  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  state_t             state;
  logic               is_int_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [31:0]        tval_q;
  logic [31:0]        epc_q;
  logic [1:0]         target_q;
  logic [31:0]        vector_q;

  // Capture-side selection, only consumed when a request is accepted in IDLE.
  logic               sel_valid;
  logic               sel_is_int;
  logic [CAUSE_W-1:0] sel_cause;
  logic [1:0]         sel_target;
  logic [31:0]        sel_tvec;
  logic [31:0]        sel_base;
  logic [31:0]        sel_vector;
  logic [15:0]        deleg_shift;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    sel_valid   = exception_valid | m_interrupt_valid | s_interrupt_valid;
    sel_is_int  = 1'b1;
    sel_cause   = s_interrupt_cause;
    sel_target  = PRIV_S;
    deleg_shift = medeleg >> exception_cause;

    if (exception_valid) begin
      sel_is_int = 1'b0;
      sel_cause  = exception_cause;
      // Exceptions taken in M never delegate, whatever medeleg says.
      sel_target = (priv != PRIV_M && deleg_shift[0]) ? PRIV_S : PRIV_M;
    end else if (m_interrupt_valid) begin
      sel_cause  = m_interrupt_cause;
      sel_target = PRIV_M;
    end

    sel_tvec = (sel_target == PRIV_M) ? mtvec : stvec;
    sel_base = {sel_tvec[31:2], 2'b00};
    // Vectored mode only applies to interrupts; exceptions always go to base.
    if (VECTORED_EN && sel_is_int && sel_tvec[1:0] == 2'b01)
      sel_vector = sel_base + {{(30-CAUSE_W){1'b0}}, sel_cause, 2'b00};
    else
      sel_vector = sel_base;
  end

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_int_q <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      target_q <= PRIV_M;
      vector_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req && sel_valid) begin
            is_int_q <= sel_is_int;
            cause_q  <= sel_cause;
            tval_q   <= sel_is_int ? 32'h0 : exception_value;
            epc_q    <= {pc[31:2], 2'b00};
            target_q <= sel_target;
            vector_q <= sel_vector;
            state    <= WR_EPC;
          end
        end
        WR_EPC:   if (csr_wr_ready) state <= WR_CAUSE;
        WR_CAUSE: if (csr_wr_ready) state <= WR_TVAL;
        WR_TVAL:  if (csr_wr_ready) state <= STATUS;
        STATUS:   state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // M-mode trap CSRs sit at 0x34x, S-mode at 0x14x.
  logic [11:0] csr_page;
  assign csr_page = (target_q == PRIV_M) ? 12'h300 : 12'h100;

  always_comb begin
    csr_wr_valid = 1'b0;
    csr_wr_addr  = 12'h000;
    csr_wr_data  = 32'h0;
    case (state)
      WR_EPC: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = csr_page | 12'h041;
        csr_wr_data  = epc_q;
      end
      WR_CAUSE: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = csr_page | 12'h042;
        csr_wr_data  = {is_int_q, {(31-CAUSE_W){1'b0}}, cause_q};
      end
      WR_TVAL: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = csr_page | 12'h043;
        csr_wr_data  = tval_q;
      end
      default: ;
    endcase
  end

  assign status_update  = (state == STATUS);
  assign status_target  = target_q;
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = vector_q;
  assign busy           = (state != IDLE);

endmodule
